// File: rtl/sequence_store_if.sv
// sequence_store_if -- command/status bundle for sequence_store.
// Groups every non-clock, non-reset signal of the sequence memory.
//   master modport : game controller side (drives commands, reads status)
//   slave  modport : sequence_store side (reads commands, drives status)
// Commands : clear, append/append_colour, play_start, step,
//            check_start, guess_valid/guess_colour
// Status   : play_valid/play_colour, play_done, guess_ok, guess_bad,
//            round_won, length, full, empty, busy
interface sequence_store_if #(
    parameter int DEPTH    = 32,
    parameter int COLOUR_W = 2,
    parameter int LW       = $clog2(DEPTH + 1)
);
    logic                clear;
    logic                append;
    logic [COLOUR_W-1:0] append_colour;
    logic                play_start;
    logic                step;
    logic                check_start;
    logic                guess_valid;
    logic [COLOUR_W-1:0] guess_colour;
    logic                play_valid;
    logic [COLOUR_W-1:0] play_colour;
    logic                play_done;
    logic                guess_ok;
    logic                guess_bad;
    logic                round_won;
    logic [LW-1:0]       length;
    logic                full;
    logic                empty;
    logic                busy;

    modport master (
        output clear, append, append_colour, play_start, step,
               check_start, guess_valid, guess_colour,
        input  play_valid, play_colour, play_done, guess_ok, guess_bad,
               round_won, length, full, empty, busy
    );

    modport slave (
        input  clear, append, append_colour, play_start, step,
               check_start, guess_valid, guess_colour,
        output play_valid, play_colour, play_done, guess_ok, guess_bad,
               round_won, length, full, empty, busy
    );
endinterface

// File: rtl/sequence_store.sv
// sequence_store -- game-sequence memory with paced playback and
// in-order guess verification.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : sequence_store_if.slave (commands in, status out)
// Holds up to DEPTH colours (mem[0] oldest) plus a length count. One
// index register walks the sequence both for playback (advanced by step)
// and for verification (advanced by each matching guess).
module sequence_store #(
    parameter int DEPTH    = 32,
    parameter int COLOUR_W = 2,
    parameter int LW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sequence_store_if.slave       bus
);
    // Array address width; length/idx carry one extra state (== DEPTH).
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       length_q, length_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic                play_valid_q, play_valid_d;
    logic [COLOUR_W-1:0] play_colour_q, play_colour_d;
    logic                play_done_q, play_done_d;
    logic                guess_ok_q, guess_ok_d;
    logic                guess_bad_q, guess_bad_d;
    logic                round_won_q, round_won_d;
    logic                mem_we_s;
    logic [COLOUR_W-1:0] mem_q [DEPTH];

    logic [LW-1:0]       idx_next_s;
    logic                idx_last_s;
    logic                full_s;

    assign idx_next_s = idx_q + LW'(1);
    assign idx_last_s = (idx_q == (length_q - LW'(1)));
    assign full_s     = (length_q == LW'(DEPTH));

    // Next-state and registered-output logic; priority clear > play_start
    // > check_start > append, and lower commands are dropped in IDLE when
    // a higher one is present even if the higher one has no effect.
    always_comb begin
        state_d       = state_q;
        length_d      = length_q;
        idx_d         = idx_q;
        play_valid_d  = play_valid_q;
        play_colour_d = play_colour_q;
        play_done_d   = 1'b0;
        guess_ok_d    = 1'b0;
        guess_bad_d   = 1'b0;
        round_won_d   = 1'b0;
        mem_we_s      = 1'b0;
        if (bus.clear) begin
            state_d      = IDLE;
            length_d     = LW'(0);
            idx_d        = LW'(0);
            play_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.play_start) begin
                        if (length_q != LW'(0)) begin
                            state_d       = PLAY;
                            idx_d         = LW'(0);
                            play_valid_d  = 1'b1;
                            play_colour_d = mem_q[0];
                        end else begin
                            // Nothing to show: report playback complete at once.
                            play_done_d = 1'b1;
                        end
                    end else if (bus.check_start) begin
                        if (length_q != LW'(0)) begin
                            state_d = CHECK;
                            idx_d   = LW'(0);
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (bus.append && !full_s) begin
                        mem_we_s = 1'b1;
                        length_d = length_q + LW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                PLAY: begin
                    if (bus.step) begin
                        if (idx_last_s) begin
                            state_d      = IDLE;
                            play_valid_d = 1'b0;
                            play_done_d  = 1'b1;
                        end else begin
                            idx_d         = idx_next_s;
                            play_colour_d = mem_q[idx_next_s[AW-1:0]];
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
                CHECK: begin
                    if (bus.guess_valid) begin
                        if (bus.guess_colour == mem_q[idx_q[AW-1:0]]) begin
                            guess_ok_d = 1'b1;
                            if (idx_last_s) begin
                                round_won_d = 1'b1;
                                state_d     = IDLE;
                            end else begin
                                idx_d = idx_next_s;
                            end
                        end else begin
                            // Sequence is kept so the same round can be replayed.
                            guess_bad_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        state_d = CHECK;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    play_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Control/state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            length_q      <= LW'(0);
            idx_q         <= LW'(0);
            play_valid_q  <= 1'b0;
            play_colour_q <= COLOUR_W'(0);
            play_done_q   <= 1'b0;
            guess_ok_q    <= 1'b0;
            guess_bad_q   <= 1'b0;
            round_won_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            length_q      <= length_d;
            idx_q         <= idx_d;
            play_valid_q  <= play_valid_d;
            play_colour_q <= play_colour_d;
            play_done_q   <= play_done_d;
            guess_ok_q    <= guess_ok_d;
            guess_bad_q   <= guess_bad_d;
            round_won_q   <= round_won_d;
        end
    end

    // Colour storage; tail write at the current length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= COLOUR_W'(0);
            end
        end else if (mem_we_s) begin
            mem_q[length_q[AW-1:0]] <= bus.append_colour;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign bus.play_valid  = play_valid_q;
    assign bus.play_colour = play_colour_q;
    assign bus.play_done   = play_done_q;
    assign bus.guess_ok    = guess_ok_q;
    assign bus.guess_bad   = guess_bad_q;
    assign bus.round_won   = round_won_q;
    assign bus.length      = length_q;
    assign bus.full        = full_s;
    assign bus.empty       = (length_q == LW'(0));
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_sequence_store.sv
// tb_sequence_store -- directed self-checking bench for sequence_store
// with DEPTH=4, COLOUR_W=2. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, i.e. one edge after a command.
module tb_sequence_store;
    localparam int DEPTH    = 4;
    localparam int COLOUR_W = 2;
    localparam int LW       = $clog2(DEPTH + 1);

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    sequence_store_if #(.DEPTH(DEPTH), .COLOUR_W(COLOUR_W)) bus ();

    sequence_store #(.DEPTH(DEPTH), .COLOUR_W(COLOUR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_append(input logic [1:0] c);
        bus.append = 1'b1;
        bus.append_colour = c;
        cyc(1);
        bus.append = 1'b0;
    endtask

    task automatic do_play_start();
        bus.play_start = 1'b1;
        cyc(1);
        bus.play_start = 1'b0;
    endtask

    task automatic do_check_start();
        bus.check_start = 1'b1;
        cyc(1);
        bus.check_start = 1'b0;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        cyc(1);
        bus.step = 1'b0;
    endtask

    task automatic do_guess(input logic [1:0] c);
        bus.guess_valid = 1'b1;
        bus.guess_colour = c;
        cyc(1);
        bus.guess_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
    endtask

    task automatic load_213();
        do_clear();
        do_append(2'd2);
        do_append(2'd1);
        do_append(2'd3);
    endtask

    initial begin
        logic [1:0] seq [3];
        n_cmp = 0;
        n_bad = 0;
        seq[0] = 2'd2;
        seq[1] = 2'd1;
        seq[2] = 2'd3;
        bus.clear = 1'b0;
        bus.append = 1'b0;
        bus.append_colour = 2'd0;
        bus.play_start = 1'b0;
        bus.step = 1'b0;
        bus.check_start = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess_colour = 2'd0;
        reset_n = 1'b0;

        // Reset values.
        #12;
        check_eq("rst_length", 32'(bus.length), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_play_valid", 32'(bus.play_valid), 32'd0);
        check_eq("rst_play_colour", 32'(bus.play_colour), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1);

        // Fill: 2,1,3 then 0 (full) then 2 (dropped).
        do_append(2'd2);
        check_eq("app1_length", 32'(bus.length), 32'd1);
        do_append(2'd1);
        do_append(2'd3);
        check_eq("app3_length", 32'(bus.length), 32'd3);
        check_eq("app3_empty", 32'(bus.empty), 32'd0);
        check_eq("app3_full", 32'(bus.full), 32'd0);
        do_append(2'd0);
        check_eq("app4_length", 32'(bus.length), 32'd4);
        check_eq("app4_full", 32'(bus.full), 32'd1);
        do_append(2'd2);
        check_eq("app5_length", 32'(bus.length), 32'd4);
        check_eq("app5_full", 32'(bus.full), 32'd1);

        // Playback of 2,1,3 with steps five cycles apart.
        load_213();
        check_eq("clr_length", 32'(bus.length), 32'd3);
        do_play_start();
        check_eq("play0_valid", 32'(bus.play_valid), 32'd1);
        check_eq("play0_colour", 32'(bus.play_colour), 32'(seq[0]));
        check_eq("play0_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i < 3; i++) begin
            cyc(4);
            check_eq("play_hold_colour", 32'(bus.play_colour), 32'(seq[i-1]));
            do_step();
            check_eq("play_step_colour", 32'(bus.play_colour), 32'(seq[i]));
            check_eq("play_step_valid", 32'(bus.play_valid), 32'd1);
            check_eq("play_step_done", 32'(bus.play_done), 32'd0);
        end
        cyc(4);
        do_step();
        check_eq("play_end_valid", 32'(bus.play_valid), 32'd0);
        check_eq("play_end_done", 32'(bus.play_done), 32'd1);
        check_eq("play_end_busy", 32'(bus.busy), 32'd0);
        cyc(1);
        check_eq("play_done_pulse", 32'(bus.play_done), 32'd0);

        // Winning verification, guesses back to back every cycle.
        do_check_start();
        check_eq("chk_busy", 32'(bus.busy), 32'd1);
        bus.guess_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.guess_colour = seq[i];
            cyc(1);
            check_eq("win_ok", 32'(bus.guess_ok), 32'd1);
            check_eq("win_bad", 32'(bus.guess_bad), 32'd0);
            check_eq("win_won", 32'(bus.round_won), (i == 2) ? 32'd1 : 32'd0);
        end
        bus.guess_valid = 1'b0;
        check_eq("win_busy", 32'(bus.busy), 32'd0);
        cyc(1);
        check_eq("win_ok_pulse", 32'(bus.guess_ok), 32'd0);
        check_eq("win_won_pulse", 32'(bus.round_won), 32'd0);

        // Losing verification: 2 then 0.
        do_check_start();
        do_guess(2'd2);
        check_eq("lose_ok1", 32'(bus.guess_ok), 32'd1);
        do_guess(2'd0);
        check_eq("lose_ok2", 32'(bus.guess_ok), 32'd0);
        check_eq("lose_bad", 32'(bus.guess_bad), 32'd1);
        check_eq("lose_won", 32'(bus.round_won), 32'd0);
        check_eq("lose_busy", 32'(bus.busy), 32'd0);
        check_eq("lose_length", 32'(bus.length), 32'd3);

        // Guess while idle is ignored.
        do_guess(2'd2);
        check_eq("idle_guess_ok", 32'(bus.guess_ok), 32'd0);
        check_eq("idle_guess_bad", 32'(bus.guess_bad), 32'd0);

        // Empty store behaviour.
        do_clear();
        check_eq("empty_flag", 32'(bus.empty), 32'd1);
        do_play_start();
        check_eq("empty_play_done", 32'(bus.play_done), 32'd1);
        check_eq("empty_play_busy", 32'(bus.busy), 32'd0);
        check_eq("empty_play_valid", 32'(bus.play_valid), 32'd0);
        do_check_start();
        check_eq("empty_chk_busy", 32'(bus.busy), 32'd0);
        check_eq("empty_chk_done", 32'(bus.play_done), 32'd0);

        // clear wins over play_start while playing.
        do_append(2'd1);
        do_play_start();
        check_eq("cp_busy_pre", 32'(bus.busy), 32'd1);
        bus.clear = 1'b1;
        bus.play_start = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.play_start = 1'b0;
        check_eq("cp_busy", 32'(bus.busy), 32'd0);
        check_eq("cp_length", 32'(bus.length), 32'd0);
        check_eq("cp_play_valid", 32'(bus.play_valid), 32'd0);

        // Asynchronous reset in the middle of a check.
        load_213();
        do_check_start();
        do_guess(2'd2);
        check_eq("ar_ok_pre", 32'(bus.guess_ok), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("ar_length", 32'(bus.length), 32'd0);
        check_eq("ar_busy", 32'(bus.busy), 32'd0);
        check_eq("ar_empty", 32'(bus.empty), 32'd1);
        check_eq("ar_ok", 32'(bus.guess_ok), 32'd0);
        check_eq("ar_play_valid", 32'(bus.play_valid), 32'd0);
        #2;
        reset_n = 1'b1;
        cyc(1);
        do_append(2'd1);
        check_eq("ar_app_length", 32'(bus.length), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sequence_store.md
# sequence_store

Parametrised game-sequence memory: the successor to the fixed 32×3-bit shift-register segment store. Holds up to DEPTH colours of COLOUR_W bits with an explicit length count, and adds the two operations the game loop needs: paced playback (one colour per timer pulse) and in-order verification of player guesses. Sits between the colour RNG, the speed timer, the LED flasher and the top-level game FSM.

## Interface
- DEPTH, 32, maximum sequence length; legal range 2..256.
- COLOUR_W, 2, bits per colour; legal range ≥1.
- LW (derived), $clog2(DEPTH+1), width of length/index.

- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous sequence wipe (new game).
- append  in  1  push append_colour at the tail.
- append_colour  in  COLOUR_W  colour to push.
- play_start  in  1  begin playback from index 0.
- step  in  1  advance playback one position (timer pulse).
- check_start  in  1  begin verification from index 0.
- guess_valid  in  1  one-cycle strobe: player guess present.
- guess_colour  in  COLOUR_W  player guess.
- play_valid  out  1  play_colour is being shown.
- play_colour  out  COLOUR_W  current playback colour.
- play_done  out  1  one-cycle pulse: playback finished.
- guess_ok  out  1  one-cycle pulse: guess matched.
- guess_bad  out  1  one-cycle pulse: guess mismatched.
- round_won  out  1  one-cycle pulse: final guess of sequence matched.
- length  out  LW  number of stored colours.
- full  out  1  length == DEPTH.
- empty  out  1  length == 0.
- busy  out  1  state ≠ IDLE.

## Operation
- Storage: DEPTH×COLOUR_W register array, mem[0] oldest; append writes mem[length], length+1.
- States: IDLE, PLAY, CHECK. Index register idx (LW bits) shared by PLAY/CHECK.
- Command priority, same cycle: clear > play_start > check_start > append.
- clear (any state): length←0, idx←0, state←IDLE, all pulses low, play_valid←0; memory contents unchanged (don't-care).
- play_start/check_start/append honoured only in IDLE; ignored in PLAY/CHECK.
- append when full: ignored, length stays DEPTH, no wrap.
- IDLE→PLAY on play_start with length>0: idx←0, play_valid←1, play_colour←mem[0].
- play_start with length==0: play_done pulses next cycle, stays IDLE.
- PLAY, step: if idx==length−1 → play_valid←0, play_done←1, IDLE; else idx+1, play_colour←mem[idx+1].
- IDLE→CHECK on check_start with length>0, idx←0. check_start with length==0 ignored.
- CHECK, guess_valid: match with mem[idx] → guess_ok; if idx==length−1 also round_won and IDLE, else idx+1. Mismatch → guess_bad, IDLE (sequence retained).
- step in CHECK/IDLE and guess_valid in PLAY/IDLE: ignored.
- full/empty/busy/length: combinational from registered length/state.

## Timing
- reset_n low (async): length=0, idx=0, state=IDLE, play_valid=0, play_colour=0, all pulses 0; full=0, empty=1, busy=0.
- All outputs registered except full/empty/busy; response one cycle after the sampling edge.
- append: length visible +1 the cycle after the edge; an appended colour is readable by a play_start in the following cycle.
- play_valid rises one cycle after play_start edge; each step updates play_colour one cycle later.
- guess_ok/guess_bad/round_won: exactly one cycle, one cycle after guess_valid edge; never both ok and bad.
- Back-to-back guess_valid every cycle must be supported.
- reset_n deassertion synchronised externally; block assumes clean release.

## Test plan
- DEPTH=4, COLOUR_W=2: reset, append 2,1,3 → length=3, empty=0, full=0; append 0,2 → length=4, full=1, second append ignored.
- Sequence 2,1,3; play_start, three step pulses 5 cycles apart → play_colour 2,1,3 with play_valid high, play_done one pulse after third step, busy=0 after.
- Sequence 2,1,3; check_start, guesses 2,1,3 → guess_ok ×3, round_won with third, state IDLE.
- Sequence 2,1,3; check_start, guesses 2,0 → guess_ok then guess_bad, no round_won, length still 3.
- Empty store: play_start → play_done pulse, busy=0; check_start → no response; clear asserted with play_start in PLAY → IDLE, length=0, play_valid=0.
- reset_n pulsed low mid-CHECK (asynchronously, between edges) → all outputs immediately at reset values; subsequent append 1 → length=1.
